// File: rtl/fa_using_ha_sync.sv
// -----------------------------------------------------------------------------
// fa_using_ha_sync
//
// Purpose:
//   One-bit full adder that is built from two half-adder instances and an OR
//   gate. It also keeps a registered copy of its result. This is the leaf
//   arithmetic cell for ripple-carry chains. The combinational outputs always
//   follow the inputs. The registered outputs give pipelined users a result
//   that is aligned to the clock cycle.
//
// Ports:
//   clk      in   system clock; the registered outputs update on the rising edge
//   rst      in   synchronous reset, active-high; clears carry_q/sum_q only
//   carry    out  combinational carry-out, A&B | Cin&(A^B)
//   sum      out  combinational sum, A^B^Cin
//   A, B     in   addend bits
//   Cin      in   carry-in bit
//   carry_q  out  carry registered on clk
//   sum_q    out  sum registered on clk
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// half_adder
//
// Purpose:
//   Two-input half adder. It is the building block of the full adder and is
//   instantiated twice.
//
// Ports:
//   carry  out  a & b
//   sum    out  a ^ b
//   a, b   in   operand bits
// -----------------------------------------------------------------------------
module half_adder (
    output logic carry,
    output logic sum,
    input  logic a,
    input  logic b
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module fa_using_ha_sync (
    input  logic clk,
    input  logic rst,
    output logic carry,
    output logic sum,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic carry_q,
    output logic sum_q
);

    logic s1;   // A ^ B, the propagate term
    logic c1;   // A & B, the generate term
    logic c2;   // carry propagated from Cin through s1

    // First stage adds the two addend bits.
    half_adder ha1 (
        .carry (c1),
        .sum   (s1),
        .a     (A),
        .b     (B)
    );

    // Second stage folds in the carry-in. Its sum output is the final sum.
    half_adder ha2 (
        .carry (c2),
        .sum   (sum),
        .a     (s1),
        .b     (Cin)
    );

    // c1 and c2 are never both 1, so an OR gate is enough to merge them.
    assign carry = c1 | c2;

    // The result register. Reset clears only these two flops. The
    // combinational path above never depends on clk or rst.
    always_ff @(posedge clk) begin
        // NOTE: Use non-blocking assignments (<=) in clocked blocks. All the
        // flops then sample their inputs at the same edge, whatever order
        // the simulator runs the processes in.
        if (rst) begin
            carry_q <= 1'b0;
            sum_q   <= 1'b0;
        end else begin
            carry_q <= carry;
            sum_q   <= sum;
        end
    end

endmodule

// File: tb/tb_fa_using_ha_sync.sv
// -----------------------------------------------------------------------------
// tb_fa_using_ha_sync
//
// Self-checking bench for fa_using_ha_sync. It covers these cases:
//   - the result while reset is held
//   - an exhaustive sweep of all eight input values on the combinational path
//   - the carry generate case and the carry propagate case
//   - the latency of the registered outputs
//   - a reset asserted in the middle of operation
//   - the propagate node inside the first half adder
//   - a randomized run checked against an arithmetic model
// -----------------------------------------------------------------------------
module tb_fa_using_ha_sync;

    logic clk = 1'b0;
    logic rst;
    logic carry, sum, carry_q, sum_q;
    logic A, B, Cin;

    int n_cmp = 0;
    int n_bad = 0;

    fa_using_ha_sync dut (
        .clk     (clk),
        .rst     (rst),
        .carry   (carry),
        .sum     (sum),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .carry_q (carry_q),
        .sum_q   (sum_q)
    );

    always #5 clk = ~clk;

    // Compares an observed 2-bit value with the expected value and records the result.
    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the 2-bit count of 1s among the three inputs.
    function automatic logic [1:0] add3(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return 2'(total);
    endfunction

    task automatic drive(input logic [2:0] abc);
        A   = abc[2];
        B   = abc[1];
        Cin = abc[0];
    endtask

    initial begin
        logic [1:0] exp_q;
        logic [2:0] v;
        logic       r;

        rst = 1'b1;
        drive(3'b111);

        // Hold reset for two edges. The flops stay clear while the combinational outputs show 3.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_regs", {carry_q, sum_q}, 2'b00);
            check("rst_comb", {carry, sum}, 2'b11);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release", {carry_q, sum_q}, 2'b11);

        // Exhaustive sweep of the combinational path, away from the clock.
        // The four Cin=0 points also check the propagate node inside ha1.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            drive(v);
            #1;
            check($sformatf("comb_%b", v), {carry, sum}, add3(int'(v[2]), int'(v[1]), int'(v[0])));
            if (v[0] == 1'b0)
                check($sformatf("s1_%b", v[2:1]), {1'b0, dut.ha1.sum},
                      (v[2] == v[1]) ? 2'b00 : 2'b01);
            #4;
        end

        // Carry generate (from c1) and carry propagate (from c2).
        drive(3'b110); #1;
        check("generate", {carry, sum}, 2'b10);
        drive(3'b011); #1;
        check("propagate", {carry, sum}, 2'b10);

        // Latency: 101 is present at edge N, and 000 is applied right after it.
        @(negedge clk); #4 drive(3'b101);
        @(posedge clk); #1 drive(3'b000);
        check("lat_edgeN", {carry_q, sum_q}, 2'b10);
        @(posedge clk); #1;
        check("lat_edgeN1", {carry_q, sum_q}, 2'b00);

        // Reset asserted in the middle of operation, with 011 held on the inputs.
        @(negedge clk); drive(3'b011);
        @(posedge clk); #1;
        check("mid_pre", {carry_q, sum_q}, 2'b10);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst", {carry_q, sum_q}, 2'b00);
        check("mid_comb", {carry, sum}, 2'b10);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("mid_post", {carry_q, sum_q}, 2'b10);

        // Randomized run: new inputs each cycle, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 9) == 0);
            drive(v);
            rst = r;
            exp_q = r ? 2'b00 : add3(int'(v[2]), int'(v[1]), int'(v[0]));
            #1;
            check("rnd_comb", {carry, sum}, add3(int'(v[2]), int'(v[1]), int'(v[0])));
            @(posedge clk); #1;
            check("rnd_regs", {carry_q, sum_q}, exp_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
